mem_resp_ctrl: RTL

Parametrised, synthesizable successor to the behavioural memory responder. It is a single-outstanding req/ack memory slave with real storage, byte-enabled writes and deterministic two-region latency. It also detects errors for out-of-range addresses and illegal commands. It sits behind the bus master under test as a drop-in target for directed and SVA-based checking.

---
 rtl/mem_resp_ctrl_pkg.sv | 23 ++
 rtl/mem_resp_ctrl_if.sv | 26 ++
 rtl/mem_resp_ctrl_store.sv | 38 +++
 rtl/mem_resp_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_resp_ctrl_pkg.sv
// Shared types and helpers for the memory responder: FSM encoding,
// latency counter width, region latency select and command error check.
package mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int LAT_W = 4;

    // Region latency: fast region below fast_limit, slow region above.
    function automatic logic [LAT_W-1:0] lat_sel(input int unsigned addr,
                                                 input int unsigned fast_limit,
                                                 input int unsigned fast_lat,
                                                 input int unsigned slow_lat);
        return (addr < fast_limit) ? fast_lat[LAT_W-1:0] : slow_lat[LAT_W-1:0];
    endfunction

    // Out-of-range address, or not exactly one of read/write.
    function automatic logic cmd_err(input logic rd, input logic wr,
                                     input int unsigned addr, input int unsigned depth);
        return (addr >= depth) || (rd == wr);
    endfunction

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// Request/response bus between a master and the memory responder.
interface mem_resp_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic                  mem_err;
    logic [DATA_W-1:0]     mem_data;

    modport master (
        output mem_req, mem_read, mem_write, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_ack, mem_err, mem_data
    );

    modport slave (
        input  mem_req, mem_read, mem_write, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_ack, mem_err, mem_data
    );
endinterface

// File: rtl/mem_resp_ctrl_store.sv
// DEPTH x DATA_W word storage: cleared on reset, byte-enabled write,
// combinational read. Out-of-range addresses read as 0 and never write.
module mem_resp_store #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NB-1:0][7:0] mem_q [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic               hit;

    assign idx = addr_i[IDX_W-1:0];
    assign hit = 32'(addr_i) < DEPTH;

    // Word array: reset clear, then per-byte update on enabled lanes.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int w = 0; w < int'(DEPTH); w++) mem_q[w] <= '0;
        end else if (we_i && hit) begin
            for (int b = 0; b < int'(NB); b++)
                if (be_i[b]) mem_q[idx][b] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = hit ? DATA_W'(mem_q[idx]) : '0;

endmodule

// File: rtl/mem_resp_ctrl.sv
// Single-outstanding req/ack memory slave with two-region latency.
// Request is latched in IDLE, counted down in WAIT, answered in RESP;
// writes commit at the end of the RESP cycle.
module mem_resp_ctrl
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned FAST_LIMIT = 64,
    parameter int unsigned FAST_LAT   = 2,
    parameter int unsigned SLOW_LAT   = 6
) (
    input logic            clk,
    input logic            aresetn,
    mem_resp_ctrl_if.slave bus
);
    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [LAT_W-1:0]      lat;
    logic                  load;
    logic                  rd_q, wr_q, err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   be_q;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;

    // State and latency counter registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat     = '0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (bus.mem_req) begin
                lat     = lat_sel(32'(bus.mem_addr), FAST_LIMIT, FAST_LAT, SLOW_LAT);
                load    = 1'b1;
                cnt_d   = lat;
                state_d = (lat == '0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q <= LAT_W'(1)) state_d = RESP;
                else                    cnt_d   = cnt_q - LAT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture; error is resolved once at accept time.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (load) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            err_q   <= cmd_err(bus.mem_read, bus.mem_write, 32'(bus.mem_addr), DEPTH);
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_be;
        end
    end

    mem_resp_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk     (clk),
        .aresetn (aresetn),
        .we_i    (ack && wr_q && !err_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (rdata)
    );

    assign ack           = (state_q == RESP);
    assign bus.mem_ready = (state_q == IDLE);
    assign bus.mem_ack   = ack;
    assign bus.mem_err   = ack && err_q;
    assign bus.mem_data  = (ack && rd_q && !err_q) ? rdata : '0;

endmodule
